// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID register and one-entry skid
//
// Issues one fetch at a time to instruction memory at the current PC. The
// returned word goes into the IF/ID register, or into a one-entry skid
// buffer when decode is stalled. When a stall arrives with a word already in
// flight, the word is parked in the skid and fetching pauses (HOLD). A taken
// branch overrides everything: it redirects the PC, flushes IF/ID and drops
// the skid.
//
// Parameters
//   RESET_PC       PC loaded on reset (word aligned)
// Ports
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   imem_req       fetch request (high in FETCH, low in HOLD)
//   imem_addr      byte address of requested word (= current PC)
//   imem_ack       memory returns imem_rdata for imem_addr this cycle
//   imem_rdata     returned instruction word
//   stall          decode holds the IF/ID register
//   branch_taken   redirect request from a later stage
//   branch_target  redirect address, low two bits forced to zero
//   instruction    IF/ID instruction (zero whenever valid is low)
//   pc_plus4       IF/ID PC+4 of that instruction
//   valid          IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    // Natural 32-bit wrap gives the modulo-2^32 PC arithmetic.
    assign pc_inc         = pc_q + 32'd4;
    assign target_aligned = branch_target & ~32'h0000_0003;

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_plus4    = pc4_q;
    assign valid       = valid_q;

    // NOTE: every signal gets its hold value before any branch below, so no
    // path through the block leaves a signal unassigned and no latch is built.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (branch_taken) begin
            // Redirect wins over stall and over an ack in the same cycle.
            pc_d         = target_aligned;
            instr_d      = 32'h0;
            valid_d      = 1'b0;
            skid_instr_d = 32'h0;
            skid_pc4_d   = 32'h0;
            state_d      = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            // Decode cannot take it: park the word, stop fetching.
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = pc_inc;
                            state_d      = HOLD;
                        end else begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_inc;
                            valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        // Waiting on memory: hand decode a bubble.
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d = skid_instr_q;
                        pc4_d   = skid_pc4_q;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
            // NOTE: the skid is cleared on reset so no stale word can ever be
            // promoted into IF/ID after reset.
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

endmodule
